// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshakes and shift-add multiplier
// Optional signed-overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              zero_o
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic              overflow_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(12);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;
    logic             accept;

    assign accept = valid_i && ready_o;

    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        alu_res = '0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            default: alu_res = '0;
        endcase
    end

    // One shift-add step; the final step's sum is written straight to result_o.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

`ifdef ALU_SEQ_OVF_EN
    logic ovf_res;
    always_comb begin
        ovf_res = 1'b0;
        if (ctrl_i == OP_ADD)
            ovf_res = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
        else if (ctrl_i == OP_SUB)
            ovf_res = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
`ifdef ALU_SEQ_OVF_EN
            overflow_o <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ready_o <= 1'b0;
                        if (ctrl_i == OP_MUL) begin
                            state  <= S_MUL;
                            cnt    <= CNT_W'(WIDTH - 1);
                            acc    <= '0;
                            mcand  <= src1_i;
                            mplier <= src2_i;
                        end else begin
                            state    <= S_DONE;
                            valid_o  <= 1'b1;
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
`ifdef ALU_SEQ_OVF_EN
                            overflow_o <= ovf_res;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        valid_o  <= 1'b1;
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
`ifdef ALU_SEQ_OVF_EN
                        overflow_o <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state   <= S_IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - vector table plus hand sequences, scoreboard-checked
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   ctrl = '0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] result_o;
    logic         zero_o;
`ifdef ALU_SEQ_OVF_EN
    logic         overflow_o;
`endif

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .src1_i   (src1),
        .src2_i   (src2),
        .ctrl_i   (ctrl),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o)
`ifdef ALU_SEQ_OVF_EN
        ,
        .overflow_o (overflow_o)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: compare when a handshake is visible, away from the edge.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {31'd0, valid_o}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("zero", {31'd0, zero_o}, {31'd0, e.zero});
`ifdef ALU_SEQ_OVF_EN
                check("overflow", {31'd0, overflow_o}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Returns at the cycle after the accept edge, #1 past the clock.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic [W-1:0] res, input logic zero, input logic ovf);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) check("ready_timeout", {31'd0, ready_o}, 32'd1);
        src1 = a; src2 = b; ctrl = op; valid_i = 1'b1;
        sb.push_back('{res: res, zero: zero, ovf: ovf});
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int bad_cyc;

        vecs.push_back(vec_t'{32'd5,        32'd7,        4'd2,  32'd12,       1'b0, 1'b0});
        vecs.push_back(vec_t'{32'd3,        32'd3,        4'd6,  32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'hFFFFFFFF, 32'd1,        4'd7,  32'd1,        1'b0, 1'b0});
        vecs.push_back(vec_t'{32'd1,        32'hFFFFFFFF, 4'd7,  32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'h80000000, 32'h7FFFFFFF, 4'd7,  32'd1,        1'b0, 1'b0});
        vecs.push_back(vec_t'{32'hF0F0,     32'hFF00,     4'd0,  32'hF000,     1'b0, 1'b0});
        vecs.push_back(vec_t'{32'hF0,       32'h0F,       4'd1,  32'hFF,       1'b0, 1'b0});
        vecs.push_back(vec_t'{32'd0,        32'd0,        4'd12, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back(vec_t'{32'hFFFFFFFF, 32'd0,        4'd12, 32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'hFFFFFFFF, 32'd1,        4'd2,  32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'd0,        32'd1,        4'd6,  32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back(vec_t'{32'h7FFFFFFF, 32'd1,        4'd2,  32'h80000000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{32'h80000000, 32'd1,        4'd6,  32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back(vec_t'{32'h80000000, 32'h80000000, 4'd1,  32'h80000000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{32'hFFFFFFFF, 32'd3,        4'd3,  32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back(vec_t'{32'h10000,    32'h10000,    4'd3,  32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'd7,        32'd6,        4'd3,  32'd42,       1'b0, 1'b0});
        vecs.push_back(vec_t'{32'hFFFFFFFE, 32'hFFFFFFFD, 4'd3,  32'd6,        1'b0, 1'b0});
        vecs.push_back(vec_t'{32'd5,        32'd7,        4'd4,  32'd0,        1'b1, 1'b0});
        vecs.push_back(vec_t'{32'd5,        32'd7,        4'd15, 32'd0,        1'b1, 1'b0});

        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zero, vecs[i].ovf);
            drain();
        end

        // Single-cycle latency: valid at N+1, ready back at N+2.
        @(posedge clk); #1;
        do_op(32'd5, 32'd7, 4'd2, 32'd12, 1'b0, 1'b0);
        check("add_valid_n1", {31'd0, valid_o}, 32'd1);
        check("add_ready_n1", {31'd0, ready_o}, 32'd0);
        @(posedge clk); #1;
        check("add_ready_n2", {31'd0, ready_o}, 32'd1);
        check("add_valid_n2", {31'd0, valid_o}, 32'd0);
        drain();

        // MUL occupies exactly W cycles before valid_o rises.
        do_op(32'hFFFFFFFF, 32'd3, 4'd3, 32'hFFFFFFFD, 1'b0, 1'b0);
        bad_cyc = 0;
        for (int k = 0; k < W; k++) begin
            if (valid_o || ready_o) bad_cyc++;
            @(posedge clk); #1;
        end
        check("mul_busy_cycles", bad_cyc, 0);
        check("mul_valid_n33", {31'd0, valid_o}, 32'd1);
        drain();

        // Backpressure: output held, new valid_i pulses ignored.
        ready_i = 1'b0;
        do_op(32'hF0F0, 32'hFF00, 4'd0, 32'hF000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, valid_o}, 32'd1);
            check("bp_result", result_o, 32'hF000);
            src1 = 32'd1; src2 = 32'd1; ctrl = 4'd2; valid_i = (k % 2 == 0);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", {31'd0, valid_o}, 32'd0);
        check("bp_ready_back", {31'd0, ready_o}, 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("bp_sb_empty", sb.size(), 0);

        // Reset during MUL cycle 10 abandons the op.
        do_op(32'd5, 32'd7, 4'd2, 32'd12, 1'b0, 1'b0);
        drain();
        @(posedge clk); #1;
        do_op(32'd5, 32'd7, 4'd3, 32'd35, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_zero", {31'd0, zero_o}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check("post_rst_valid", {31'd0, valid_o}, 32'd0);
        do_op(32'd1, 32'd1, 4'd2, 32'd2, 1'b0, 1'b0);
        drain();

        repeat (40) begin
            @(posedge clk); #1;
        end
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
